// File: rtl/smart_car_pkg.sv
// Shared types and 50 MHz timing defaults for the smart-car sensor and motion blocks.
package smart_car_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TRIG,
    WAIT_ECHO,
    MEASURE
  } ranger_state_t;

  localparam int unsigned DEF_TRIG_CYCLES    = 500;
  localparam int unsigned DEF_PERIOD_CYCLES  = 3000000;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1500000;
  localparam int unsigned DEF_CM_CYCLES      = 2900;
  localparam int unsigned DEF_DIST_W         = 9;
  localparam int unsigned DEF_NEAR_CM        = 20;
  localparam int unsigned DEF_FAR_CM         = 25;

  function automatic int unsigned dist_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  localparam int unsigned DIST_MAX = dist_max(DEF_DIST_W);

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous level, with single-cycle rise/fall pulses.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= d;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/ultrasonic_ranger.sv
// HC-SR04-style ranger: periodic trigger, echo timing in centimetres, obstacle flag with hysteresis.
module ultrasonic_ranger
  import smart_car_pkg::*;
#(
  parameter int unsigned TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int unsigned PERIOD_CYCLES  = DEF_PERIOD_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CM_CYCLES      = DEF_CM_CYCLES,
  parameter int unsigned DIST_W         = DEF_DIST_W,
  parameter int unsigned NEAR_CM        = DEF_NEAR_CM,
  parameter int unsigned FAR_CM         = DEF_FAR_CM
) (
  input  logic              clk0,
  input  logic              rst_n,
  input  logic              en,
  input  logic              echo,
  output logic              trig,
  output logic              ssig,
  output logic [DIST_W-1:0] dist_cm,
  output logic              dist_valid,
  output logic              timeout
);

  localparam int unsigned CNT_LIM = (TIMEOUT_CYCLES > TRIG_CYCLES) ? TIMEOUT_CYCLES : TRIG_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_LIM + 1);
  localparam int unsigned PER_W   = $clog2(PERIOD_CYCLES + 1);
  localparam int unsigned SUB_W   = $clog2(CM_CYCLES + 1);
  localparam logic [DIST_W-1:0] DIST_TOP = DIST_W'(dist_max(DIST_W));

  ranger_state_t     state, state_next;
  logic [PER_W-1:0]  pcnt;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [SUB_W-1:0]  cm_sub, cm_sub_next;
  logic [DIST_W-1:0] cm_cnt, cm_cnt_next;
  logic              echo_rise, echo_fall;
  logic              cycle_start;
  logic              meas_done, meas_timeout;

  sync_edge u_echo_sync (
    .clk   (clk0),
    .rst_n (rst_n),
    .d     (echo),
    .rise  (echo_rise),
    .fall  (echo_fall)
  );

  assign cycle_start = en && (pcnt == '0);
  assign trig        = (state == TRIG);

  always_comb begin
    state_next   = state;
    cnt_next     = cnt + CNT_W'(1);
    cm_sub_next  = cm_sub;
    cm_cnt_next  = cm_cnt;
    meas_done    = 1'b0;
    meas_timeout = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_next = '0;
        if (cycle_start) state_next = TRIG;
      end
      TRIG: begin
        if (cnt == CNT_W'(TRIG_CYCLES - 1)) begin
          state_next = WAIT_ECHO;
          cnt_next   = '0;
        end
      end
      WAIT_ECHO: begin
        if (echo_rise) begin
          state_next  = MEASURE;
          cnt_next    = '0;
          cm_sub_next = '0;
          cm_cnt_next = '0;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          meas_timeout = 1'b1;
          state_next   = IDLE;
          cnt_next     = '0;
        end
      end
      MEASURE: begin
        // The fall cycle itself is counted, so the latched distance uses the
        // post-increment value rather than the registered one.
        if (cm_sub == SUB_W'(CM_CYCLES - 1)) begin
          cm_sub_next = '0;
          if (cm_cnt != DIST_TOP) cm_cnt_next = cm_cnt + DIST_W'(1);
        end else begin
          cm_sub_next = cm_sub + SUB_W'(1);
        end
        if (echo_fall) begin
          meas_done  = 1'b1;
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          meas_timeout = 1'b1;
          state_next   = IDLE;
          cnt_next     = '0;
        end
      end
      default: state_next = IDLE;
    endcase
    if (!en) begin
      state_next   = IDLE;
      cnt_next     = '0;
      cm_sub_next  = '0;
      cm_cnt_next  = '0;
      meas_done    = 1'b0;
      meas_timeout = 1'b0;
    end
  end

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pcnt       <= '0;
      cnt        <= '0;
      cm_sub     <= '0;
      cm_cnt     <= '0;
      dist_cm    <= '0;
      dist_valid <= 1'b0;
      timeout    <= 1'b0;
      ssig       <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      cm_sub     <= cm_sub_next;
      cm_cnt     <= cm_cnt_next;
      dist_valid <= meas_done | meas_timeout;
      if (!en || pcnt == PER_W'(PERIOD_CYCLES - 1)) pcnt <= '0;
      else                                          pcnt <= pcnt + PER_W'(1);
      if (meas_timeout) begin
        dist_cm <= DIST_TOP;
        timeout <= 1'b1;
        ssig    <= 1'b0;
      end else if (meas_done) begin
        dist_cm <= cm_cnt_next;
        timeout <= 1'b0;
        if (cm_cnt_next <= DIST_W'(NEAR_CM))     ssig <= 1'b1;
        else if (cm_cnt_next >= DIST_W'(FAR_CM)) ssig <= 1'b0;
      end else if (!en) begin
        ssig <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed self-checking bench for ultrasonic_ranger with short timing parameters.
module tb_ultrasonic_ranger;
  import smart_car_pkg::*;

  logic       clk0 = 1'b0;
  logic       rst_n;
  logic       en;
  logic       echo;
  logic       trig;
  logic       ssig;
  logic [8:0] dist_cm;
  logic       dist_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;
  bit saw_measure = 1'b0;

  ultrasonic_ranger #(
    .TRIG_CYCLES    (5),
    .PERIOD_CYCLES  (400),
    .TIMEOUT_CYCLES (150),
    .CM_CYCLES      (4),
    .DIST_W         (9),
    .NEAR_CM        (20),
    .FAR_CM         (25)
  ) dut (
    .clk0       (clk0),
    .rst_n      (rst_n),
    .en         (en),
    .echo       (echo),
    .trig       (trig),
    .ssig       (ssig),
    .dist_cm    (dist_cm),
    .dist_valid (dist_valid),
    .timeout    (timeout)
  );

  always #5 clk0 = ~clk0;

  always @(negedge clk0) if (dut.state == MEASURE) saw_measure = 1'b1;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  // Sensor model: wait for a trigger, answer after delay cycles with an echo high
  // for high cycles (high=0 leaves echo untouched), then capture the dist_valid cycle.
  task automatic sensor_cycle(input int delay, input int high, output int trig_len,
                              output bit got, output logic [8:0] d, output logic s,
                              output logic t, output int lat, output logic pulse_after);
    int n;
    trig_len = 0; got = 1'b0; d = '0; s = 1'b0; t = 1'b0; lat = 0; pulse_after = 1'b1;
    n = 0;
    while (trig !== 1'b1 && n < 1000) begin @(negedge clk0); n++; end
    while (trig === 1'b1 && trig_len < 100) begin @(negedge clk0); trig_len++; end
    if (high > 0) begin
      repeat (delay) @(negedge clk0);
      lat += delay;
      echo = 1'b1;
      repeat (high) @(negedge clk0);
      lat += high;
      echo = 1'b0;
    end
    while (dist_valid !== 1'b1 && lat < 400) begin @(negedge clk0); lat++; end
    got = (dist_valid === 1'b1);
    d = dist_cm; s = ssig; t = timeout;
    @(negedge clk0);
    pulse_after = dist_valid;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b0; echo = 1'b0;
    repeat (3) @(negedge clk0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk0);
    checks++; if (trig !== 1'b0) begin errors++; $display("FAIL reset_trig: got %0b expected 0", trig); end
    checks++; if (ssig !== 1'b0) begin errors++; $display("FAIL reset_ssig: got %0b expected 0", ssig); end
    checks++; if (dist_cm !== 9'd0) begin errors++; $display("FAIL reset_dist: got %0d expected 0", dist_cm); end
    checks++; if (dist_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", dist_valid); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %0b expected 0", timeout); end
  endtask

  task automatic test_basic;
    int tl, lat; bit got; logic [8:0] d; logic s, t, pa;
    en = 1'b1;
    sensor_cycle(10, 40, tl, got, d, s, t, lat, pa);
    checks++; if (tl !== 5) begin errors++; $display("FAIL basic_trig_len: got %0d expected 5", tl); end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b expected 1", got); end
    checks++; if (d !== 9'd10) begin errors++; $display("FAIL basic_dist: got %0d expected 10", d); end
    checks++; if (s !== 1'b1) begin errors++; $display("FAIL basic_ssig: got %0b expected 1", s); end
    checks++; if (t !== 1'b0) begin errors++; $display("FAIL basic_timeout: got %0b expected 0", t); end
    checks++; if (pa !== 1'b0) begin errors++; $display("FAIL basic_valid_one_cycle: got %0b expected 0", pa); end
  endtask

  task automatic test_hysteresis;
    int tl, lat; bit got; logic [8:0] d; logic s, t, pa;
    int          hi   [4] = '{120, 88, 80, 92};
    logic [8:0]  ed   [4] = '{9'd30, 9'd22, 9'd20, 9'd23};
    logic        es   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      sensor_cycle(10, hi[i], tl, got, d, s, t, lat, pa);
      checks++; if (d !== ed[i]) begin errors++; $display("FAIL hyst_dist[%0d]: got %0d expected %0d", i, d, ed[i]); end
      checks++; if (s !== es[i]) begin errors++; $display("FAIL hyst_ssig[%0d]: got %0b expected %0b", i, s, es[i]); end
    end
  endtask

  task automatic test_timeout;
    int tl, lat; bit got; logic [8:0] d; logic s, t, pa;
    sensor_cycle(0, 0, tl, got, d, s, t, lat, pa);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL to_valid: got %0b expected 1", got); end
    checks++; if (lat !== 150) begin errors++; $display("FAIL to_latency: got %0d expected 150", lat); end
    checks++; if (d !== 9'd511) begin errors++; $display("FAIL to_dist: got %0d expected 511", d); end
    checks++; if (t !== 1'b1) begin errors++; $display("FAIL to_flag: got %0b expected 1", t); end
    checks++; if (s !== 1'b0) begin errors++; $display("FAIL to_ssig: got %0b expected 0", s); end
    checks++; if (pa !== 1'b0) begin errors++; $display("FAIL to_valid_one_cycle: got %0b expected 0", pa); end
    sensor_cycle(10, 40, tl, got, d, s, t, lat, pa);
    checks++; if (t !== 1'b0) begin errors++; $display("FAIL to_recover_flag: got %0b expected 0", t); end
    checks++; if (d !== 9'd10) begin errors++; $display("FAIL to_recover_dist: got %0d expected 10", d); end
  endtask

  task automatic test_echo_stuck;
    int tl, lat; bit got; logic [8:0] d; logic s, t, pa;
    echo = 1'b1;
    saw_measure = 1'b0;
    sensor_cycle(0, 0, tl, got, d, s, t, lat, pa);
    checks++; if (lat !== 150) begin errors++; $display("FAIL stuck_latency: got %0d expected 150", lat); end
    checks++; if (t !== 1'b1) begin errors++; $display("FAIL stuck_timeout: got %0b expected 1", t); end
    checks++; if (d !== 9'd511) begin errors++; $display("FAIL stuck_dist: got %0d expected 511", d); end
    checks++; if (saw_measure !== 1'b0) begin errors++; $display("FAIL stuck_no_measure: got %0b expected 0", saw_measure); end
    echo = 1'b0;
  endtask

  task automatic test_en_drop;
    int tl, lat, n, pulses; bit got; logic [8:0] d, d0; logic s, t, pa, t0;
    sensor_cycle(10, 40, tl, got, d, s, t, lat, pa);
    checks++; if (s !== 1'b1) begin errors++; $display("FAIL en_pre_ssig: got %0b expected 1", s); end
    n = 0; while (trig !== 1'b1 && n < 1000) begin @(negedge clk0); n++; end
    n = 0; while (trig === 1'b1 && n < 100) begin @(negedge clk0); n++; end
    repeat (10) @(negedge clk0);
    echo = 1'b1;
    repeat (20) @(negedge clk0);
    checks++; if (dut.state !== MEASURE) begin errors++; $display("FAIL en_in_measure: got %0d expected %0d", dut.state, MEASURE); end
    d0 = dist_cm; t0 = timeout;
    en = 1'b0;
    @(negedge clk0);
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL en_idle: got %0d expected %0d", dut.state, IDLE); end
    checks++; if (ssig !== 1'b0) begin errors++; $display("FAIL en_ssig: got %0b expected 0", ssig); end
    checks++; if (trig !== 1'b0) begin errors++; $display("FAIL en_trig: got %0b expected 0", trig); end
    echo = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (dist_valid === 1'b1) pulses++;
      @(negedge clk0);
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL en_no_valid: got %0d expected 0", pulses); end
    checks++; if (dist_cm !== d0) begin errors++; $display("FAIL en_dist_held: got %0d expected %0d", dist_cm, d0); end
    checks++; if (timeout !== t0) begin errors++; $display("FAIL en_timeout_held: got %0b expected %0b", timeout, t0); end
    en = 1'b1;
    @(negedge clk0);
    checks++; if (trig !== 1'b1) begin errors++; $display("FAIL en_restart_trig: got %0b expected 1", trig); end
    n = 0; while (trig === 1'b1 && n < 100) begin @(negedge clk0); n++; end
    n = 0; while (dist_valid !== 1'b1 && n < 400) begin @(negedge clk0); n++; end
    @(negedge clk0);
  endtask

  task automatic test_async_reset;
    int tl, lat, n; bit got; logic [8:0] d; logic s, t, pa;
    sensor_cycle(10, 40, tl, got, d, s, t, lat, pa);
    checks++; if (s !== 1'b1) begin errors++; $display("FAIL ar_pre_ssig: got %0b expected 1", s); end
    n = 0; while (trig !== 1'b1 && n < 1000) begin @(negedge clk0); n++; end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (trig !== 1'b0) begin errors++; $display("FAIL ar_trig: got %0b expected 0", trig); end
    checks++; if (ssig !== 1'b0) begin errors++; $display("FAIL ar_ssig: got %0b expected 0", ssig); end
    checks++; if (dist_cm !== 9'd0) begin errors++; $display("FAIL ar_dist: got %0d expected 0", dist_cm); end
    rst_n = 1'b1;
    sensor_cycle(10, 88, tl, got, d, s, t, lat, pa);
    checks++; if (tl !== 5) begin errors++; $display("FAIL ar_resume_trig_len: got %0d expected 5", tl); end
    checks++; if (d !== 9'd22) begin errors++; $display("FAIL ar_resume_dist: got %0d expected 22", d); end
    checks++; if (s !== 1'b0) begin errors++; $display("FAIL ar_resume_ssig: got %0b expected 0", s); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hysteresis();
    test_timeout();
    test_echo_stuck();
    test_en_drop();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
